sequenciador_carga: RTL
=======================

Name: sequenciador_carga

Overview:
- Program-load sequencer and RAM-ownership arbiter for the SAP-1 core.
- Accepts a stream of program bytes over a valid/ready handshake and writes them into the 16x8 RAM at addresses 0..15, holding the CPU in clear while loading.
- After the last write it hands the RAM back to the CPU and releases it to run.
- On HLT from the control unit it returns to idle; a new load can be started at any time.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM/program byte width
WORDS, 16, bytes per load image (must equal 2**ADDR_W)

Ports:
CLK  in  1  system clock; all logic on rising edge
CLR  in  1  synchronous, active-high reset
start_load  in  1  request to (re)start a program load; level sampled each cycle
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  DATA_W  program byte
byte_ready  out  1  sequencer accepts a byte this cycle (combinational)
halt_in  in  1  HLT decoded by the control unit
ram_sel  out  1  1 = sequencer owns the RAM address/data/write path; 0 = CPU owns it
ram_we  out  1  one-cycle RAM write strobe
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
cpu_clr  out  1  clear to PC, IR and control unit
cpu_run  out  1  1 while the CPU executes
carga_ok  out  1  a complete image has been loaded since the last start_load
estado  out  2  FSM state: 0 IDLE, 1 CARGA, 2 PARTIDA, 3 EXEC
cont_bytes  out  ADDR_W+1  bytes accepted in the current load (0..WORDS)

Behaviour:
- Reset (CLR=1 at an edge) forces these values on the next cycle, whatever the state, including mid-load and mid-write:
  - estado=IDLE, cpu_clr=1, cpu_run=0, ram_sel=0, ram_we=0, ram_addr=0, ram_wdata=0, carga_ok=0, cont_bytes=0.
  - Any pending write is dropped.
- Handshake:
  - A byte transfers when byte_valid & byte_ready at a rising edge.
  - byte_ready = (estado==CARGA) & ~start_load.
  - byte_valid with byte_ready=0 is ignored, with no side effects.
- Write path is registered:
  - On transfer with cont_bytes=N, the next cycle has ram_we=1, ram_addr=N[ADDR_W-1:0] and ram_wdata=byte.
  - cont_bytes becomes N+1.
  - ram_we is low in every other cycle.
  - Back-to-back transfers give back-to-back writes at consecutive addresses.
- IDLE: cpu_clr=1, cpu_run=0, ram_sel=0. On start_load go to CARGA with cont_bytes=0, carga_ok=0, ram_sel=1.
- CARGA:
  - cpu_clr=1, ram_sel=1.
  - On the transfer that makes cont_bytes=WORDS, go to PARTIDA.
  - start_load while in CARGA restarts the load: cont_bytes=0, no byte accepted that cycle, and earlier-written bytes are simply overwritten later.
- PARTIDA (exactly 1 cycle):
  - The write of byte WORDS-1 is issued here.
  - ram_sel=1, cpu_clr=1.
  - Next state is EXEC.
- EXEC: ram_sel=0, cpu_clr=0, cpu_run=1, carga_ok=1.
  - halt_in=1: go to IDLE. cpu_run=0 and cpu_clr=1 from the next cycle; carga_ok stays 1.
  - start_load=1: abort the run and go to CARGA. cpu_clr=1 and ram_sel=1 next cycle; carga_ok=0.
  - If halt_in and start_load are both 1, start_load wins.
- halt_in is ignored outside EXEC; start_load is ignored in PARTIDA.
- cont_bytes saturates at WORDS and cannot wrap. ram_addr wraps naturally because it is the low ADDR_W bits.
- ram_sel never changes in the same cycle as a ram_we pulse to a different owner, so there is no bus contention.

Test Plan:
- CLR for 2 cycles from arbitrary state -> estado=0, cpu_clr=1, cpu_run=0, ram_we=0, carga_ok=0, cont_bytes=0.
- start_load, then 16 back-to-back bytes 0x10..0x1F ->
  - 16 consecutive ram_we pulses at addr 0..15 carrying 0x10..0x1F;
  - exactly one PARTIDA cycle;
  - then cpu_run=1, cpu_clr=0, ram_sel=0, carga_ok=1.
- Load with byte_valid toggling 1/0 and 3-cycle gaps ->
  - writes only on transfer cycles, addresses still 0..15 in order;
  - a 17th valid byte after completion is not accepted (byte_ready=0).
- Restart after 5 bytes (start_load pulse), then 16 bytes 0xA0..0xAF ->
  - cont_bytes returns to 0;
  - final writes at addr 0..15 carry 0xA0..0xAF;
  - no write occurs in the start_load cycle.
- EXEC then halt_in=1 -> next cycle estado=IDLE, cpu_run=0, cpu_clr=1, carga_ok=1. halt_in=1 during CARGA -> no effect.
- In EXEC, halt_in=1 and start_load=1 together -> estado=CARGA, carga_ok=0; CLR asserted mid-load at cont_bytes=7 -> IDLE, no further ram_we.

Source files
------------

// File: rtl/sequenciador_carga.sv
// Program-load sequencer and RAM-ownership arbiter for the SAP-1 core.
// Streams a 16-byte image into RAM while the CPU is held in clear, then
// hands the RAM back and lets the CPU run until HLT or a new load request.
module sequenciador_carga #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int WORDS  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start_load,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  input  logic              halt_in,
  output logic              ram_sel,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_clr,
  output logic              cpu_run,
  output logic              carga_ok,
  output logic [1:0]        estado,
  output logic [ADDR_W:0]   cont_bytes
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CARGA   = 2'd1;
  localparam logic [1:0] ST_PARTIDA = 2'd2;
  localparam logic [1:0] ST_EXEC    = 2'd3;

  // Byte count that completes an image, and the count just before it.
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(WORDS);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(WORDS - 1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W:0]   cont_reg, cont_next;
  logic              ok_reg, ok_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              transfer;

  // A load request always takes priority over accepting a byte.
  assign byte_ready = (state_reg == ST_CARGA) && !start_load;
  assign transfer   = byte_valid && byte_ready;

  // Next-state, byte counter and load-complete flag.
  always_comb begin
    state_next = state_reg;
    cont_next  = cont_reg;
    ok_next    = ok_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_load) begin
          state_next = ST_CARGA;
          cont_next  = '0;
          ok_next    = 1'b0;
        end
      end
      ST_CARGA: begin
        if (start_load) begin
          cont_next = '0;
        end else if (transfer) begin
          if (cont_reg != FULL_CNT) begin
            cont_next = cont_reg + 1'b1;
          end
          if (cont_reg == LAST_CNT) begin
            state_next = ST_PARTIDA;
          end
        end
      end
      ST_PARTIDA: begin
        // Last write is on the bus this cycle; the image is complete.
        state_next = ST_EXEC;
        ok_next    = 1'b1;
      end
      default: begin
        if (start_load) begin
          state_next = ST_CARGA;
          cont_next  = '0;
          ok_next    = 1'b0;
        end else if (halt_in) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Registered write path: one strobe per accepted byte, one cycle later.
  always_comb begin
    we_next    = transfer;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    if (transfer) begin
      addr_next  = cont_reg[ADDR_W-1:0];
      wdata_next = byte_data;
    end
  end

  // State registers; reset also drops any write that would be pending.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= ST_IDLE;
      cont_reg  <= '0;
      ok_reg    <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cont_reg  <= cont_next;
      ok_reg    <= ok_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // RAM ownership and CPU control decode straight from the state.
  always_comb begin
    ram_sel = (state_reg == ST_CARGA) || (state_reg == ST_PARTIDA);
    cpu_clr = (state_reg != ST_EXEC);
    cpu_run = (state_reg == ST_EXEC);
  end

  assign ram_we     = we_reg;
  assign ram_addr   = addr_reg;
  assign ram_wdata  = wdata_reg;
  assign carga_ok   = ok_reg;
  assign estado     = state_reg;
  assign cont_bytes = cont_reg;

endmodule
